i2c_slave_sm: RTL and testbench

I2C target (responder) for the test-board control path: the far end of the bus driven by the I2C master state machine and its start/busy stretcher. Oversamples SCL/SDA on the 50 MHz system clock, detects START/STOP, decodes a 7-bit address plus an 8-bit register pointer, and performs byte writes and reads against an external register file. The pointer auto-increments for burst transfers.

---
 rtl/i2c_pkg.sv | 18 +
 rtl/i2c_slave_sm_if.sv | 16 +
 rtl/i2c_slave_filter.sv | 39 +++
 rtl/i2c_slave_sm.sv | 167 ++++++++++++++++
 tb/tb_i2c_slave_sm.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared constants for the I2C register-file target: state encoding and bus bit values.
package i2c_pkg;
    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE      = 4'd0;
    localparam state_t ST_ADDR      = 4'd1;
    localparam state_t ST_ADDR_ACK  = 4'd2;
    localparam state_t ST_PTR       = 4'd3;
    localparam state_t ST_PTR_ACK   = 4'd4;
    localparam state_t ST_WDATA     = 4'd5;
    localparam state_t ST_WDATA_ACK = 4'd6;
    localparam state_t ST_RDATA     = 4'd7;
    localparam state_t ST_RDATA_ACK = 4'd8;
    localparam state_t ST_IGNORE    = 4'd9;

    localparam logic I2C_RW_READ = 1'b1;
    localparam logic ACK         = 1'b0;
endpackage

// File: rtl/i2c_slave_sm_if.sv
// Pad and register-file signals of the I2C target, grouped for the top-level port.
interface i2c_slave_sm_if;
    logic       SCL_IN;
    logic       SDA_IN;
    logic       SDA_OE;
    logic [7:0] REG_ADDR;
    logic [7:0] REG_WDATA;
    logic       REG_WE;
    logic [7:0] REG_RDATA;
    logic       BUSY;

    modport slave  (input  SCL_IN, SDA_IN, REG_RDATA,
                    output SDA_OE, REG_ADDR, REG_WDATA, REG_WE, BUSY);
    modport master (output SCL_IN, SDA_IN, REG_RDATA,
                    input  SDA_OE, REG_ADDR, REG_WDATA, REG_WE, BUSY);
endinterface

// File: rtl/i2c_slave_filter.sv
// 2-flop pad synchronizer; with I2C_SLAVE_GLITCH_FILTER_EN defined a 3-sample
// majority vote follows it to reject single-cycle pulses.
module i2c_slave_filter (
    input  logic clk,
    input  logic rst_n,
    input  logic pad_i,
    output logic line_o
);
    logic [1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[0], pad_i};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= sync_d;

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [1:0] hist_q, hist_d;
    logic       maj_q, maj_d;

    always_comb begin
        hist_d = {hist_q[0], sync_q[1]};
        maj_d  = (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            hist_q <= 2'b11;
            maj_q  <= 1'b1;
        end else begin
            hist_q <= hist_d;
            maj_q  <= maj_d;
        end

    assign line_o = maj_q;
`else
    assign line_o = sync_q[1];
`endif
endmodule

// File: rtl/i2c_slave_sm.sv
// I2C target with 8-bit register pointer and auto-increment burst read/write.
// Optional pad glitch filter: I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_sm
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic           CLK,
    input  logic           RST_N,
    i2c_slave_sm_if.slave  bus
);
    logic   scl, sda;
    logic   scl_h_q, scl_h_d, sda_h_q, sda_h_d;
    state_t state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] sh_q, sh_d, reg_addr_q, reg_addr_d, reg_wdata_q, reg_wdata_d;
    logic   sda_oe_q, sda_oe_d, busy_q, busy_d, reg_we_q, reg_we_d;
    logic   rw_q, rw_d, ack_ph_q, ack_ph_d;

    i2c_slave_filter u_scl_filt (.clk(CLK), .rst_n(RST_N), .pad_i(bus.SCL_IN), .line_o(scl));
    i2c_slave_filter u_sda_filt (.clk(CLK), .rst_n(RST_N), .pad_i(bus.SDA_IN), .line_o(sda));

    logic scl_rise, scl_fall, start_det, stop_det, shifting, byte_end, addr_hit;
    logic [7:0] shift_byte;

    assign scl_rise   = scl & ~scl_h_q;
    assign scl_fall   = ~scl & scl_h_q;
    assign start_det  = scl & scl_h_q & sda_h_q & ~sda;
    assign stop_det   = scl & scl_h_q & ~sda_h_q & sda;
    assign shifting   = (state_q == ST_ADDR) || (state_q == ST_PTR) || (state_q == ST_WDATA);
    assign byte_end   = scl_rise && (bit_cnt_q == 3'd7) && (shifting || state_q == ST_RDATA);
    assign shift_byte = {sh_q[6:0], sda};
    assign addr_hit   = (shift_byte[7:1] == SLAVE_ADDR);

    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;

    // ack_ph_q splits each ACK slot: 0 = before the fall that opens it, 1 = inside it
    always_comb begin
        state_d = state_q;
        if (stop_det)       state_d = ST_IDLE;
        else if (start_det) state_d = ST_ADDR;
        else begin
            case (state_q)
                ST_ADDR:      if (byte_end) state_d = addr_hit ? ST_ADDR_ACK : ST_IGNORE;
                ST_PTR:       if (byte_end) state_d = ST_PTR_ACK;
                ST_WDATA:     if (byte_end) state_d = ST_WDATA_ACK;
                ST_RDATA:     if (byte_end) state_d = ST_RDATA_ACK;
                ST_ADDR_ACK:  if (scl_fall && ack_ph_q) state_d = (rw_q == I2C_RW_READ) ? ST_RDATA : ST_PTR;
                ST_PTR_ACK,
                ST_WDATA_ACK: if (scl_fall && ack_ph_q) state_d = ST_WDATA;
                ST_RDATA_ACK: begin
                    if (scl_rise && ack_ph_q && sda != ACK) state_d = ST_IGNORE;
                    else if (scl_fall && ack_ph_q)         state_d = ST_RDATA;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        scl_h_d     = scl;
        sda_h_d     = sda;
        bit_cnt_d   = bit_cnt_q;
        sh_d        = sh_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        rw_d        = rw_q;
        ack_ph_d    = ack_ph_q;
        // write pointer advances the cycle after the strobe
        if (reg_we_q) reg_addr_d = reg_addr_q + 8'd1;
        if (stop_det) begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 3'd0;
        end else begin
            if (scl_rise && shifting) begin
                sh_d      = shift_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            if (scl_rise && state_q == ST_RDATA) bit_cnt_d = bit_cnt_q + 3'd1;
            if (byte_end) ack_ph_d = 1'b0;
            case (state_q)
                ST_ADDR: if (byte_end && addr_hit) begin
                    busy_d = 1'b1;
                    rw_d   = sda;
                end
                ST_PTR:   if (byte_end) reg_addr_d = shift_byte;
                ST_WDATA: if (byte_end) begin
                    reg_wdata_d = shift_byte;
                    reg_we_d    = 1'b1;
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
                    if (!ack_ph_q) begin
                        sda_oe_d = 1'b1;
                        ack_ph_d = 1'b1;
                    end else begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 3'd0;
                        if (state_q == ST_ADDR_ACK && rw_q == I2C_RW_READ) begin
                            sh_d     = bus.REG_RDATA;
                            sda_oe_d = ~bus.REG_RDATA[7];
                        end
                    end
                end
                ST_RDATA: if (scl_fall) begin
                    sh_d     = {sh_q[6:0], 1'b0};
                    sda_oe_d = ~sh_q[6];
                end
                ST_RDATA_ACK: begin
                    if (scl_fall && !ack_ph_q) begin
                        sda_oe_d = 1'b0;
                        ack_ph_d = 1'b1;
                    end else if (scl_rise && ack_ph_q) begin
                        if (sda == ACK) reg_addr_d = reg_addr_q + 8'd1;
                        else            busy_d     = 1'b0;
                    end else if (scl_fall) begin
                        sh_d      = bus.REG_RDATA;
                        sda_oe_d  = ~bus.REG_RDATA[7];
                        bit_cnt_d = 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            scl_h_q     <= 1'b1;
            sda_h_q     <= 1'b1;
            bit_cnt_q   <= 3'd0;
            sh_q        <= 8'd0;
            reg_addr_q  <= 8'd0;
            reg_wdata_q <= 8'd0;
            reg_we_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            rw_q        <= 1'b0;
            ack_ph_q    <= 1'b0;
        end else begin
            scl_h_q     <= scl_h_d;
            sda_h_q     <= sda_h_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_q        <= sh_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            rw_q        <= rw_d;
            ack_ph_q    <= ack_ph_d;
        end

    assign bus.SDA_OE    = sda_oe_q;
    assign bus.REG_ADDR  = reg_addr_q;
    assign bus.REG_WDATA = reg_wdata_q;
    assign bus.REG_WE    = reg_we_q;
    assign bus.BUSY      = busy_q;
endmodule

// File: tb/tb_i2c_slave_sm.sv
// Directed bench for i2c_slave_sm: bus-level master model plus register-file model.
module tb_i2c_slave_sm;
    import i2c_pkg::*;
    localparam int Q = 20;
    localparam int H = 20;

    logic clk = 1'b0, rst_n = 1'b0, scl_drv = 1'b1, sda_drv = 1'b1;
    logic [7:0] mem [256];
    logic [7:0] we_addr [64];
    logic [7:0] we_data [64];
    int n_cmp = 0, n_err = 0, we_cnt = 0, oe_cnt = 0;

    i2c_slave_sm_if bus_if ();
    assign bus_if.SCL_IN    = scl_drv;
    assign bus_if.SDA_IN    = sda_drv & ~bus_if.SDA_OE;
    assign bus_if.REG_RDATA = mem[bus_if.REG_ADDR];

    i2c_slave_sm #(.SLAVE_ADDR(7'h50)) dut (.CLK(clk), .RST_N(rst_n), .bus(bus_if));

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (bus_if.REG_WE) begin
            we_addr[we_cnt] = bus_if.REG_ADDR;
            we_data[we_cnt] = bus_if.REG_WDATA;
            we_cnt++;
        end
        if (bus_if.SDA_OE) oe_cnt++;
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start;
        sda_drv = 1'b1; clks(Q); scl_drv = 1'b1; clks(Q);
        sda_drv = 1'b0; clks(Q); scl_drv = 1'b0; clks(Q);
    endtask

    task automatic i2c_stop;
        sda_drv = 1'b0; clks(Q); scl_drv = 1'b1; clks(Q); sda_drv = 1'b1; clks(Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input int glitch_bit);
        for (int i = 7; i > 7 - n; i--) begin
            sda_drv = b[i]; clks(Q); scl_drv = 1'b1; clks(H);
            if (i == glitch_bit) begin scl_drv = 1'b0; clks(1); scl_drv = 1'b1; end
            clks(H); scl_drv = 1'b0; clks(Q);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
        send_bits(b, 8, glitch_bit);
        sda_drv = 1'b1; clks(Q); scl_drv = 1'b1; clks(H);
        ack = bus_if.SDA_IN;
        clks(H); scl_drv = 1'b0; clks(Q);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_drv = 1'b1; clks(Q); scl_drv = 1'b1; clks(H);
            b[i] = bus_if.SDA_IN;
            clks(H); scl_drv = 1'b0; clks(Q);
        end
        sda_drv = nack; clks(Q); scl_drv = 1'b1; clks(2 * H); scl_drv = 1'b0; clks(Q);
        sda_drv = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; clks(3);
        n_cmp++; if (bus_if.SDA_OE !== 1'b0) begin n_err++; $display("FAIL rst_sda_oe: got %b want 0", bus_if.SDA_OE); end
        n_cmp++; if (bus_if.REG_ADDR !== 8'h00) begin n_err++; $display("FAIL rst_reg_addr: got %h want 00", bus_if.REG_ADDR); end
        n_cmp++; if (bus_if.REG_WDATA !== 8'h00) begin n_err++; $display("FAIL rst_reg_wdata: got %h want 00", bus_if.REG_WDATA); end
        n_cmp++; if (bus_if.REG_WE !== 1'b0) begin n_err++; $display("FAIL rst_reg_we: got %b want 0", bus_if.REG_WE); end
        n_cmp++; if (bus_if.BUSY !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus_if.BUSY); end
        rst_n = 1'b1; clks(5);
        n_cmp++; if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL rst_state: got %0d want %0d", dut.state_q, ST_IDLE); end
    endtask

    task automatic test_write;
        logic a;
        logic [7:0] seq [4];
        int w0;
        seq = '{8'hA0, 8'h10, 8'h5A, 8'h3C};
        w0 = we_cnt;
        i2c_start;
        for (int i = 0; i < 4; i++) begin
            send_byte(seq[i], -1, a);
            n_cmp++; if (a !== ACK) begin n_err++; $display("FAIL wr_ack%0d: got %b want 0", i, a); end
        end
        n_cmp++; if (bus_if.BUSY !== 1'b1) begin n_err++; $display("FAIL wr_busy: got %b want 1", bus_if.BUSY); end
        i2c_stop; clks(5);
        n_cmp++; if (we_cnt - w0 !== 2) begin n_err++; $display("FAIL wr_we_count: got %0d want 2", we_cnt - w0); end
        n_cmp++; if (we_addr[w0] !== 8'h10 || we_data[w0] !== 8'h5A) begin n_err++; $display("FAIL wr_we0: got %h/%h want 10/5a", we_addr[w0], we_data[w0]); end
        n_cmp++; if (we_addr[w0+1] !== 8'h11 || we_data[w0+1] !== 8'h3C) begin n_err++; $display("FAIL wr_we1: got %h/%h want 11/3c", we_addr[w0+1], we_data[w0+1]); end
        n_cmp++; if (bus_if.REG_ADDR !== 8'h12) begin n_err++; $display("FAIL wr_ptr_end: got %h want 12", bus_if.REG_ADDR); end
        n_cmp++; if (bus_if.BUSY !== 1'b0) begin n_err++; $display("FAIL wr_busy_stop: got %b want 0", bus_if.BUSY); end
    endtask

    task automatic test_read(input logic [7:0] ptr, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] ptr_end);
        logic a0, a1, a2;
        logic [7:0] r0, r1;
        int w0;
        w0 = we_cnt;
        mem[ptr] = d0; mem[ptr + 8'd1] = d1;
        i2c_start;
        send_byte(8'hA0, -1, a0); send_byte(ptr, -1, a1);
        i2c_start;
        send_byte(8'hA1, -1, a2);
        n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_err++; $display("FAIL rd_acks_%h: got %b want 000", ptr, {a0, a1, a2}); end
        read_byte(1'b0, r0);
        read_byte(1'b1, r1);
        n_cmp++; if (r0 !== d0) begin n_err++; $display("FAIL rd_byte0_%h: got %h want %h", ptr, r0, d0); end
        n_cmp++; if (r1 !== d1) begin n_err++; $display("FAIL rd_byte1_%h: got %h want %h", ptr, r1, d1); end
        n_cmp++; if (bus_if.BUSY !== 1'b0) begin n_err++; $display("FAIL rd_busy_nack_%h: got %b want 0", ptr, bus_if.BUSY); end
        i2c_stop; clks(5);
        n_cmp++; if (bus_if.REG_ADDR !== ptr_end) begin n_err++; $display("FAIL rd_ptr_end_%h: got %h want %h", ptr, bus_if.REG_ADDR, ptr_end); end
        n_cmp++; if (we_cnt !== w0) begin n_err++; $display("FAIL rd_no_we_%h: got %0d want %0d", ptr, we_cnt, w0); end
    endtask

    task automatic test_bad_addr;
        logic a0, a1;
        int w0, o0;
        w0 = we_cnt; o0 = oe_cnt;
        i2c_start;
        send_byte(8'hB0, -1, a0);
        n_cmp++; if (bus_if.BUSY !== 1'b0) begin n_err++; $display("FAIL bad_busy: got %b want 0", bus_if.BUSY); end
        send_byte(8'h55, -1, a1);
        i2c_stop; clks(5);
        n_cmp++; if ({a0, a1} !== 2'b11) begin n_err++; $display("FAIL bad_nack: got %b want 11", {a0, a1}); end
        n_cmp++; if (oe_cnt !== o0) begin n_err++; $display("FAIL bad_sda_oe: got %0d want %0d", oe_cnt, o0); end
        n_cmp++; if (we_cnt !== w0) begin n_err++; $display("FAIL bad_no_we: got %0d want %0d", we_cnt, w0); end
    endtask

    task automatic test_wrap_write;
        logic a0, a1, a2, a3;
        int w0;
        w0 = we_cnt;
        i2c_start;
        send_byte(8'hA0, -1, a0); send_byte(8'hFF, -1, a1);
        send_byte(8'h11, -1, a2); send_byte(8'h22, -1, a3);
        i2c_stop; clks(5);
        n_cmp++; if (we_cnt - w0 !== 2) begin n_err++; $display("FAIL wrap_we_count: got %0d want 2", we_cnt - w0); end
        n_cmp++; if (we_addr[w0] !== 8'hFF || we_data[w0] !== 8'h11) begin n_err++; $display("FAIL wrap_we0: got %h/%h want ff/11", we_addr[w0], we_data[w0]); end
        n_cmp++; if (we_addr[w0+1] !== 8'h00 || we_data[w0+1] !== 8'h22) begin n_err++; $display("FAIL wrap_we1: got %h/%h want 00/22", we_addr[w0+1], we_data[w0+1]); end
        n_cmp++; if (bus_if.REG_ADDR !== 8'h01) begin n_err++; $display("FAIL wrap_ptr_end: got %h want 01", bus_if.REG_ADDR); end
    endtask

    task automatic test_stop_mid;
        logic a0, a1;
        int w0;
        w0 = we_cnt;
        i2c_start;
        send_byte(8'hA0, -1, a0); send_byte(8'h30, -1, a1);
        send_bits(8'hF0, 4, -1);
        i2c_stop; clks(5);
        n_cmp++; if (we_cnt !== w0) begin n_err++; $display("FAIL stopmid_no_we: got %0d want %0d", we_cnt, w0); end
        n_cmp++; if (dut.state_q !== ST_IDLE) begin n_err++; $display("FAIL stopmid_state: got %0d want %0d", dut.state_q, ST_IDLE); end
        n_cmp++; if (bus_if.SDA_OE !== 1'b0) begin n_err++; $display("FAIL stopmid_sda_oe: got %b want 0", bus_if.SDA_OE); end
        n_cmp++; if (bus_if.BUSY !== 1'b0) begin n_err++; $display("FAIL stopmid_busy: got %b want 0", bus_if.BUSY); end
        n_cmp++; if (bus_if.REG_ADDR !== 8'h30) begin n_err++; $display("FAIL stopmid_ptr: got %h want 30", bus_if.REG_ADDR); end
    endtask

    task automatic test_rst_mid_read;
        logic a0, a1, a2, a3;
        int w0;
        mem[8'h40] = 8'h00;
        i2c_start;
        send_byte(8'hA0, -1, a0); send_byte(8'h40, -1, a1);
        i2c_start;
        send_byte(8'hA1, -1, a2);
        for (int i = 0; i < 3; i++) begin
            clks(Q); scl_drv = 1'b1; clks(2 * H); scl_drv = 1'b0; clks(Q);
        end
        n_cmp++; if (bus_if.SDA_OE !== 1'b1) begin n_err++; $display("FAIL rstmid_bit3_drive: got %b want 1", bus_if.SDA_OE); end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus_if.SDA_OE !== 1'b0) begin n_err++; $display("FAIL rstmid_sda_oe: got %b want 0", bus_if.SDA_OE); end
        n_cmp++; if (bus_if.REG_ADDR !== 8'h00) begin n_err++; $display("FAIL rstmid_ptr: got %h want 00", bus_if.REG_ADDR); end
        clks(2); rst_n = 1'b1; clks(5);
        sda_drv = 1'b1; clks(Q); scl_drv = 1'b1; clks(Q);
        w0 = we_cnt;
        i2c_start;
        send_byte(8'hA0, -1, a0); send_byte(8'h50, -1, a1); send_byte(8'h77, -1, a3);
        i2c_stop; clks(5);
        n_cmp++; if ({a0, a1, a3} !== 3'b000) begin n_err++; $display("FAIL rstmid_acks: got %b want 000", {a0, a1, a3}); end
        n_cmp++; if (we_cnt - w0 !== 1 || we_addr[w0] !== 8'h50 || we_data[w0] !== 8'h77) begin
            n_err++; $display("FAIL rstmid_write: got n=%0d %h/%h want n=1 50/77", we_cnt - w0, we_addr[w0], we_data[w0]);
        end
    endtask

    task automatic test_glitch;
        logic a, exp_a;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        exp_a = 1'b0;
`else
        exp_a = 1'b1;
`endif
        i2c_start;
        send_byte(8'hA0, 7, a);
        i2c_stop; clks(5);
        n_cmp++; if (a !== exp_a) begin n_err++; $display("FAIL glitch_addr_ack: got %b want %b", a, exp_a); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        test_reset;
        test_write;
        test_read(8'h20, 8'h81, 8'h7E, 8'h21);
        test_read(8'hFF, 8'hC3, 8'h96, 8'h00);
        test_bad_addr;
        test_wrap_write;
        test_stop_mid;
        test_rst_mid_read;
        test_glitch;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
